// File: rtl/ttt_turn_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : ttt_turn_controller_if
// Description : Bundle between the player-input logic (master) and the
//               tic-tac-toe turn controller (slave).
//               master drives : new_game, tick_en, move_valid, move_pos
//               slave drives  : move_ready, move_err, timeout, dec_pos, dec_en,
//                               player, board_x, board_o, game_over, winner
// Revision    : 1.0 - initial release
// ============================================================================
interface ttt_turn_controller_if;
    logic       new_game;
    logic       tick_en;
    logic       move_valid;
    logic [3:0] move_pos;
    logic       move_ready;
    logic       move_err;
    logic       timeout;
    logic [3:0] dec_pos;
    logic       dec_en;
    logic       player;
    logic [8:0] board_x;
    logic [8:0] board_o;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output new_game, tick_en, move_valid, move_pos,
        input  move_ready, move_err, timeout, dec_pos, dec_en,
               player, board_x, board_o, game_over, winner
    );

    modport slave (
        input  new_game, tick_en, move_valid, move_pos,
        output move_ready, move_err, timeout, dec_pos, dec_en,
               player, board_x, board_o, game_over, winner
    );
endinterface
`default_nettype wire

// File: rtl/ttt_turn_controller.sv
`default_nettype none
// ============================================================================
// Module      : ttt_turn_controller
// Description : Tic-tac-toe move sequencer. Accepts cell requests from the
//               active player, rejects illegal cells, pulses the position
//               decoder once per committed move, keeps X/O occupancy maps,
//               detects win/draw and forces a move when the turn timer expires.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - ttt_turn_controller_if.slave (move request side and
//                      decoder/display side, see interface file)
// Parameters  : TURN_TICKS - tick_en pulses per turn before a forced move (1..255)
// Revision    : 1.0 - initial release
// ============================================================================
module ttt_turn_controller #(
    parameter int TURN_TICKS = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    ttt_turn_controller_if.slave        bus
);

    localparam logic [2:0] c_st_wait_move = 3'd0;
    localparam logic [2:0] c_st_check     = 3'd1;
    localparam logic [2:0] c_st_commit    = 3'd2;
    localparam logic [2:0] c_st_eval      = 3'd3;
    localparam logic [2:0] c_st_game_over = 3'd4;

    localparam logic [7:0] c_tick_last = 8'(TURN_TICKS - 1);
    localparam logic [8:0] c_full      = 9'h1FF;

    logic [2:0] r_state;
    logic [7:0] r_timer;
    logic [3:0] r_pos;
    logic       r_player;
    logic [8:0] r_board_x;
    logic [8:0] r_board_o;
    logic [3:0] r_dec_pos;
    logic       r_dec_en;
    logic       r_move_err;
    logic       r_timeout;
    logic [1:0] r_winner;

    logic [8:0] w_occ;
    logic [8:0] w_map;
    logic [3:0] w_free_pos;
    logic       w_win;
    logic       w_pos_bad;

    // Lowest-index empty cell; only consulted while at least one cell is free.
    function automatic logic [3:0] first_free(input logic [8:0] occ);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (!occ[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic has_line(input logic [8:0] m);
        return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) |
               (m[6] & m[7] & m[8]) | (m[0] & m[3] & m[6]) |
               (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
               (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
    endfunction

    always_comb begin
        w_occ      = r_board_x | r_board_o;
        w_map      = r_player ? r_board_o : r_board_x;
        w_free_pos = first_free(w_occ);
        w_win      = has_line(w_map);
        // Shift-based lookup so positions 9..15 never index past the map.
        w_pos_bad  = (r_pos > 4'd8) || (|(w_occ & (9'b1 << r_pos)));
    end

    always_ff @(posedge clk) begin
        if (rst || bus.new_game) begin
            r_state    <= c_st_wait_move;
            r_timer    <= 8'd0;
            r_pos      <= 4'd0;
            r_player   <= 1'b0;
            r_board_x  <= 9'd0;
            r_board_o  <= 9'd0;
            r_dec_pos  <= 4'd0;
            r_dec_en   <= 1'b0;
            r_move_err <= 1'b0;
            r_timeout  <= 1'b0;
            r_winner   <= 2'b00;
        end else begin
            // Single-cycle pulses default low.
            r_dec_en   <= 1'b0;
            r_move_err <= 1'b0;
            r_timeout  <= 1'b0;

            case (r_state)
                c_st_wait_move: begin
                    // A request on the expiry cycle takes precedence over the timer.
                    if (bus.move_valid) begin
                        r_pos   <= bus.move_pos;
                        r_state <= c_st_check;
                    end else if (bus.tick_en) begin
                        if (r_timer == c_tick_last) begin
                            r_pos     <= w_free_pos;
                            r_dec_pos <= w_free_pos;
                            r_dec_en  <= 1'b1;
                            r_timeout <= 1'b1;
                            r_timer   <= 8'd0;
                            r_state   <= c_st_commit;
                        end else begin
                            r_timer <= r_timer + 8'd1;
                        end
                    end
                end
                c_st_check: begin
                    if (w_pos_bad) begin
                        r_move_err <= 1'b1;
                        r_state    <= c_st_wait_move;
                    end else begin
                        // Decoder strobe is registered so it lands in COMMIT.
                        r_dec_pos <= r_pos;
                        r_dec_en  <= 1'b1;
                        r_state   <= c_st_commit;
                    end
                end
                c_st_commit: begin
                    if (r_player) r_board_o <= r_board_o | (9'b1 << r_pos);
                    else          r_board_x <= r_board_x | (9'b1 << r_pos);
                    r_state <= c_st_eval;
                end
                c_st_eval: begin
                    if (w_win) begin
                        r_winner <= r_player ? 2'b10 : 2'b01;
                        r_state  <= c_st_game_over;
                    end else if (w_occ == c_full) begin
                        r_winner <= 2'b11;
                        r_state  <= c_st_game_over;
                    end else begin
                        r_player <= ~r_player;
                        r_timer  <= 8'd0;
                        r_state  <= c_st_wait_move;
                    end
                end
                c_st_game_over: begin
                    r_state <= c_st_game_over;
                end
                default: begin
                    r_state <= c_st_wait_move;
                end
            endcase
        end
    end

    assign bus.move_ready = (r_state == c_st_wait_move);
    assign bus.game_over  = (r_state == c_st_game_over);
    assign bus.move_err   = r_move_err;
    assign bus.timeout    = r_timeout;
    assign bus.dec_pos    = r_dec_pos;
    assign bus.dec_en     = r_dec_en;
    assign bus.player     = r_player;
    assign bus.board_x    = r_board_x;
    assign bus.board_o    = r_board_o;
    assign bus.winner     = r_winner;

endmodule
`default_nettype wire
